// File: rtl/lsp_cb0_quant.sv
// Nearest-neighbour quantizer for LSP codebook 0: scans 16 entries, one per cycle, 17-cycle latency.
// Optional squared-error metric enabled by defining LSP_CB0_SQERR_EN; default reports absolute error.
module lsp_cb0_quant #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] target,
    output logic         busy,
    output logic         done,
    output logic [3:0]   index,
    output logic [63:0]  min_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_target;
    logic [3:0]   r_addr;
    logic [63:0]  r_best_err;
    logic [3:0]   r_best_idx;
    logic         r_busy;
    logic         r_done;
    logic [3:0]   r_index;
    logic [63:0]  r_min_err;

    logic         w_accept;
    logic         w_search;
    logic         w_finish;
    logic [N-1:0] w_cb;
    logic [N:0]   w_diff;
    logic [N:0]   w_absd;
    logic [63:0]  w_err;

    // Codebook entry k is (225 + 25*k) with zero fraction bits.
    assign w_cb   = N'((32'd225 + 32'd25 * 32'(r_addr)) << 16);
    assign w_diff = {r_target[N-1], r_target} - {w_cb[N-1], w_cb};
    assign w_absd = w_diff[N] ? (~w_diff + 1'b1) : w_diff;

`ifdef LSP_CB0_SQERR_EN
    assign w_err = 64'(w_absd) * 64'(w_absd);
`else
    assign w_err = 64'(w_absd);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SEARCH;
            S_SEARCH: if (r_addr == 4'd15) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_search = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE:   w_accept = start;
            S_SEARCH: w_search = 1'b1;
            S_DONE:   w_finish = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target   <= '0;
            r_addr     <= '0;
            r_best_err <= '1;
            r_best_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_index    <= '0;
            r_min_err  <= '0;
        end else begin
            r_busy <= (r_state != S_IDLE);
            r_done <= w_finish;
            if (w_accept) begin
                r_target   <= target;
                r_addr     <= '0;
                r_best_err <= '1;
                r_best_idx <= '0;
            end
            // Strict compare keeps the lowest index on ties.
            if (w_search) begin
                if (w_err < r_best_err) begin
                    r_best_err <= w_err;
                    r_best_idx <= r_addr;
                end
                r_addr <= r_addr + 4'd1;
            end
            if (w_finish) begin
                r_index   <= r_best_idx;
                r_min_err <= r_best_err;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign index   = r_index;
    assign min_err = r_min_err;

endmodule

// File: tb/tb_lsp_cb0_quant.sv
// Directed bench for lsp_cb0_quant; expected values are hand-derived absolute errors,
// squared inside the bench when LSP_CB0_SQERR_EN is defined.
module tb_lsp_cb0_quant;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] target;
    logic        busy;
    logic        done;
    logic [3:0]  index;
    logic [63:0] min_err;

    int n_vec  = 0;
    int n_fail = 0;

    lsp_cb0_quant #(.N(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .target  (target),
        .busy    (busy),
        .done    (done),
        .index   (index),
        .min_err (min_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_err(input logic [63:0] absd);
`ifdef LSP_CB0_SQERR_EN
        return absd * absd;
`else
        return absd;
`endif
    endfunction

    // Launch one request, then wait (bounded) for done and check latency and result.
    task automatic run(input string tag, input logic [31:0] t, input logic [3:0] exp_idx,
                       input logic [63:0] exp_abs);
        int c;
        bit seen;
        @(negedge clk);
        start  = 1'b1;
        target = t;
        @(posedge clk);
        #1 start = 1'b0;
        target = 32'h0;
        seen = 1'b0;
        c = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            c = i;
            if (i == 1) chk({tag, "_busy_c1"}, 64'(busy), 64'd1);
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(c), 64'd17);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        chk({tag, "_index"}, 64'(index), 64'(exp_idx));
        chk({tag, "_min_err"}, min_err, exp_err(exp_abs));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        chk({tag, "_index_hold"}, 64'(index), 64'(exp_idx));
    endtask

    initial begin
        int n_done;
        int done_cyc;
        rst    = 1'b1;
        start  = 1'b0;
        target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_index", 64'(index), 64'd0);
        chk("rst_min_err", min_err, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("t225",   32'h00E1_0000, 4'd0,  64'h0);
        run("t312p5", 32'h0138_8000, 4'd3,  64'h000C_8000);
        run("t1000",  32'h03E8_0000, 4'd15, 64'h0190_0000);
        run("tneg5",  32'hFFFB_0000, 4'd0,  64'h00E6_0000);
        run("t410",   32'h019A_0000, 4'd7,  64'h000A_0000);
        run("t600",   32'h0258_0000, 4'd15, 64'h0);
        run("t230p5", 32'h00E6_8000, 4'd0,  64'h0005_8000);

        // Extra start pulses at cycles 5 and 17 must be ignored.
        @(negedge clk);
        start  = 1'b1;
        target = 32'h0190_0000;
        @(posedge clk);
        #1 start = 1'b0;
        n_done   = 0;
        done_cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5 || i == 17) begin
                start  = 1'b1;
                target = 32'h0258_0000;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                n_done++;
                done_cyc = i;
                chk("ign_index", 64'(index), 64'd7);
                chk("ign_min_err", min_err, exp_err(64'h0));
            end
            if (i == 18 || i == 19) chk("ign_not_accepted", 64'(busy), 64'd0);
        end
        chk("ign_done_count", 64'(n_done), 64'd1);
        chk("ign_done_cycle", 64'(done_cyc), 64'd17);

        // Reset at cycle 8 aborts the search without a done.
        @(negedge clk);
        start  = 1'b1;
        target = 32'h0138_8000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_index", 64'(index), 64'd0);
        chk("abort_min_err", min_err, 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        run("after_rst", 32'h01C2_0000, 4'd9, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
